// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx: buffers golden-nonce pulses in a FIFO and reports each as a UART 8N1 frame, MSB byte first.
// Optional feature: define GOLDEN_NONCE_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module golden_nonce_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_LOG2    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 golden_valid,
    input  logic [31:0]          golden_nonce,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_LOG2:0]   fifo_count
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned CW    = FIFO_LOG2 + 1;
    localparam int unsigned PW    = FIFO_LOG2;
    localparam int unsigned TW    = 16;
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
    localparam int unsigned LAST_BYTE = 4;
`else
    localparam int unsigned LAST_BYTE = 3;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [31:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [TW-1:0]     r_timer;
    logic [2:0]        r_bit_idx;
    logic [2:0]        r_byte_idx;
    logic [31:0]       r_shift;
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_tick;
    logic              w_last_byte;
    logic              w_frame_done;
    logic [7:0]        w_cur_byte;
    logic [31:0]       w_head;
    logic [CW-1:0]     w_count_nxt;
    logic              w_busy_nxt;

    // FIFO handshake, bit timing and next-cycle occupancy/busy
    always_comb begin
        w_full       = (fifo_count == CW'(DEPTH));
        w_pop        = (r_state == S_IDLE) && (fifo_count != '0);
        w_push       = golden_valid && (!w_full || w_pop);
        w_tick       = (r_timer == TW'(CLKS_PER_BIT - 1));
        w_last_byte  = (r_byte_idx == 3'(LAST_BYTE));
        w_frame_done = (r_state == S_STOP) && w_tick && w_last_byte;
        w_head       = r_mem[r_rd_ptr];
        w_cur_byte   = r_shift[31:24];
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
        if (r_byte_idx == 3'd4) begin
            w_cur_byte = r_csum;
        end
`endif
        w_count_nxt = fifo_count;
        if (w_push && !w_pop) begin
            w_count_nxt = fifo_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = fifo_count - CW'(1);
        end
        w_busy_nxt = (w_count_nxt != '0) || w_pop || ((r_state != S_IDLE) && !w_frame_done);
    end

    // Storage has no reset; stale entries are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= golden_nonce;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
            r_csum     <= '0;
`endif
            tx         <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (golden_valid && w_full && !w_pop) begin
                overflow <= 1'b1;
            end
            fifo_count <= w_count_nxt;
            busy       <= w_busy_nxt;

            // tx is loaded with the level of the state being entered
            case (r_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_rd_ptr   <= r_rd_ptr + PW'(1);
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
                        r_csum     <= w_head[31:24] ^ w_head[23:16] ^ w_head[15:8] ^ w_head[7:0];
`endif
                        r_timer    <= '0;
                        r_byte_idx <= '0;
                        r_state    <= S_START;
                        tx         <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        tx        <= w_cur_byte[0];
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            tx      <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            tx        <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (w_last_byte) begin
                            r_state <= S_IDLE;
                            tx      <= 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_shift    <= {r_shift[23:0], 8'h00};
                            r_state    <= S_START;
                            tx         <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Bench for golden_nonce_tx: a UART decoder checks sent bytes and inter-byte spacing against a queue of expected bytes.
// Covers reset, single frame, burst/overflow, full FIFO with simultaneous pop, mid-frame reset, and the checksum build.
module tb_golden_nonce_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned FL2 = 2;
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
    localparam int NBYTES = 5;
`else
    localparam int NBYTES = 4;
`endif
    localparam int BYTE_LEN  = 10 * CPB;
    localparam int FRAME_LEN = BYTE_LEN * NBYTES;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           golden_valid = 1'b0;
    logic [31:0]    golden_nonce = 32'h0;
    logic           tx;
    logic           busy;
    logic           overflow;
    logic [FL2:0]   fifo_count;

    golden_nonce_tx #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(FL2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .golden_valid (golden_valid),
        .golden_nonce (golden_nonce),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected bytes of one frame; gap is start-to-start distance from the previous byte (0 = unchecked)
    task automatic push_nonce(input logic [31:0] n, input int first_gap);
        exp_t e;
        logic [7:0] cs = 8'h00;
        for (int b = 0; b < 4; b++) begin
            e.data = 8'(n >> (24 - 8 * b));
            e.gap  = (b == 0) ? first_gap : BYTE_LEN;
            cs     = cs ^ e.data;
            exp_q.push_back(e);
        end
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
        e.data = cs;
        e.gap  = BYTE_LEN;
        exp_q.push_back(e);
`endif
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // UART decoder sampling on the falling edge
    initial begin
        logic       active = 1'b0;
        int         cnt = 0;
        logic [7:0] byte_v = 8'h00;
        int         st = 0;
        int         last = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                    last   = st;
                    st     = cyc;
                end
            end else begin
                cnt++;
                if (cnt == 2) begin
                    check("start_bit", 32'(tx), 32'd0);
                end else if (cnt >= 5 && cnt <= 33 && ((cnt - 5) % 4) == 0) begin
                    byte_v[3'((cnt - 5) / 4)] = tx;
                end else if (cnt == 37) begin
                    active = 1'b0;
                    check("stop_bit", 32'(tx), 32'd1);
                    check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("byte_value", 32'(byte_v), 32'(e.data));
                        if (e.gap != 0) check("byte_spacing", st - last, e.gap);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tx_low;
        exp_t e;

        // Reset values
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single nonce
        push_nonce(32'hDEADBEEF, 0);
        golden_valid = 1'b1; golden_nonce = 32'hDEADBEEF;
        @(posedge clk); #1;
        golden_valid = 1'b0;
        check("single_count", 32'(fifo_count), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("single_start_latency", 32'(tx), 32'd0);
        check("single_pop_count", 32'(fifo_count), 32'd0);
        wait_idle(n);
        check("single_frame_len", n, FRAME_LEN);
        check("single_tx_idle", 32'(tx), 32'd1);
        check("single_drained", exp_q.size(), 0);

        // Burst of 6: value 6 dropped
        for (int v = 1; v <= 6; v++) begin
            if (v <= 5) push_nonce(32'(v), (v == 1) ? 0 : BYTE_LEN + 1);
            golden_valid = 1'b1; golden_nonce = 32'(v);
            @(posedge clk); #1;
        end
        golden_valid = 1'b0;
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_count", 32'(fifo_count), 32'd4);
        wait_idle(n);
        check("burst_len", n, 5 * FRAME_LEN);
        check("burst_drained", exp_q.size(), 0);

        // Clear sticky overflow
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_clears_overflow", 32'(overflow), 32'd0);

        // Full FIFO with a push on the IDLE pop cycle
        push_nonce(32'hA0A1A2A3, 0);
        golden_valid = 1'b1; golden_nonce = 32'hA0A1A2A3;
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            push_nonce(32'hB0B1B2B0 + 32'(k), BYTE_LEN + 1);
            golden_nonce = 32'hB0B1B2B0 + 32'(k);
            @(posedge clk); #1;
        end
        golden_valid = 1'b0;
        check("full_count", 32'(fifo_count), 32'd4);
        repeat (FRAME_LEN - 3) @(posedge clk);
        #1;
        check("full_idle_tx", 32'(tx), 32'd1);
        check("full_idle_count", 32'(fifo_count), 32'd4);
        push_nonce(32'hC3C2C1C0, BYTE_LEN + 1);
        golden_valid = 1'b1; golden_nonce = 32'hC3C2C1C0;
        @(posedge clk); #1;
        golden_valid = 1'b0;
        check("full_pop_push_count", 32'(fifo_count), 32'd4);
        check("full_pop_push_overflow", 32'(overflow), 32'd0);
        check("full_next_start", 32'(tx), 32'd0);
        wait_idle(n);
        check("full_len", n, 5 * FRAME_LEN + 4);
        check("full_drained", exp_q.size(), 0);

`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
        // Checksum byte 12^34^56^78 = 08
        push_nonce(32'h12345678, 0);
        check("csum_model", 32'(exp_q[4].data), 32'h08);
        golden_valid = 1'b1; golden_nonce = 32'h12345678;
        @(posedge clk); #1;
        golden_valid = 1'b0;
        @(posedge clk); #1;
        wait_idle(n);
        check("csum_frame_len", n, 200);
        check("csum_drained", exp_q.size(), 0);
`endif

        // Reset during DATA of byte 2 with two entries queued
        e.data = 8'h5A; e.gap = 0;
        exp_q.push_back(e);
        golden_valid = 1'b1;
        golden_nonce = 32'h5A5AC3C3; @(posedge clk); #1;
        golden_nonce = 32'h11111111; @(posedge clk); #1;
        golden_nonce = 32'h22222222; @(posedge clk); #1;
        golden_valid = 1'b0;
        repeat (47) @(posedge clk);
        #1;
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_count", 32'(fifo_count), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        tx_low = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) tx_low++;
        end
        check("midreset_no_frames", tx_low, 0);
        check("midreset_busy_after", 32'(busy), 32'd0);
        check("midreset_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/golden_nonce_tx.md
# golden_nonce_tx

Serial result reporter for the mining core. It accepts single-cycle golden-nonce pulses from the hashing control unit and buffers them in a small FIFO. Each nonce is sent to the host as a framed UART 8N1 byte stream on one output pin. It is the outbound end of the miner's host link: the hasher finds nonces, and this block delivers them.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- FIFO_LOG2, default 2: FIFO depth is 2^FIFO_LOG2 nonces. Legal range 1..4.

Ports:
- clk  input  1  hashing clock; all logic is on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- golden_valid  input  1  one-cycle pulse: golden_nonce holds a found nonce.
- golden_nonce  input  32  nonce value, sampled when golden_valid=1.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  output  1  sticky; set when a nonce is dropped because the FIFO is full.
- fifo_count  output  FIFO_LOG2+1  current FIFO occupancy.

## Operation
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0. Reset also sets the FSM to IDLE, the bit timer to 0, and the FIFO pointers to 0.
- Reset takes effect mid-frame: tx returns to 1 on the next edge, and any partial frame and all buffered nonces are discarded.
- Push:
  - If golden_valid=1 and the FIFO is not full, golden_nonce is written at the tail on that edge.
  - If golden_valid=1, the FIFO is full and no pop occurs in the same cycle, the nonce is dropped and overflow is set to 1. overflow clears only on reset.
- Pop: when the FSM is in IDLE and fifo_count>0, the head entry is loaded into a 32-bit shift register and the FSM moves to START.
- Simultaneous push and pop in one cycle: both take effect and fifo_count is unchanged. A push into a full FIFO is accepted if a pop happens in the same cycle.
- Frame format: 4 bytes, most significant byte first (nonce[31:24] first). Within each byte, LSB goes out first.
- FSM states:
  - IDLE: tx=1. Moves to START on a pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, each held for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If more bytes remain in the frame, go to START; otherwise go to IDLE.
- Counters:
  - Bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 when the state advances. It is 16 bits wide.
  - Bit index is 3 bits and byte index is 3 bits.
- busy = (fifo_count != 0) | (state != IDLE).

## Timing
- Cycle N: golden_valid=1 into an empty, idle block. fifo_count=1 is visible after edge N.
- Edge N+1: pop. fifo_count returns to 0 and tx=0 (start bit) is visible after edge N+1.
- Latency from the pulse to the first start-bit level is 2 edges.
- Byte length: 10*CLKS_PER_BIT cycles. Frame length: 40*CLKS_PER_BIT cycles.
- Gap between frames: exactly 1 IDLE cycle with tx=1 between the last stop bit and the next start bit. A pop can occur on that IDLE cycle.
- There is no gap between bytes within a frame: STOP goes directly to START.
- golden_valid pulses may arrive on back-to-back cycles. Each one is pushed independently, subject to the FIFO being full.

## Configuration
- GOLDEN_NONCE_TX_CHECKSUM_EN defined: a 5th byte is appended to every frame. It equals the XOR of the 4 nonce bytes. Frame length becomes 50*CLKS_PER_BIT cycles and the byte index counts 0..4.
- Not defined: frames are exactly 4 bytes and there is no checksum logic.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_LOG2=2.
- Single nonce: pulse golden_nonce=32'hDEADBEEF. Required response: tx shows bytes DE, AD, BE, EF, each as start 0, LSB-first data, stop 1; 160 cycles from the first start bit to the end of the last stop bit; busy falls 1 cycle after the last stop.
- Burst and overflow: 6 back-to-back pulses with values 1..6 while idle.
  - Value 1 is popped on the 2nd cycle, so values 1..5 are retained and value 6 is dropped.
  - Required response: overflow=1; frames 1, 2, 3, 4, 5 appear in order, each separated by exactly 1 idle cycle.
- Full FIFO with simultaneous pop: fill the FIFO to 4 while a frame is in flight, then pulse on the cycle the IDLE pop occurs. Required response: the nonce is accepted, overflow stays 0, and fifo_count stays 4.
- Reset mid-frame: assert rst_n=0 for 1 cycle during the DATA state of byte 2, with 2 entries queued. Required response: tx=1, fifo_count=0, overflow=0 and busy=0 after the edge; no further frames are sent.
- With the checksum macro enabled: send 32'h12345678. Required response: a 5th byte 0x08 follows, and the frame is 200 cycles long.
- Reset values: hold reset and check tx=1, busy=0, overflow=0, fifo_count=0 after the first edge.
